// File: rtl/wb_write_queue_if.sv
// Writeback request handshake plus register-file write port of the writeback queue.
// master = request producer / register-file side, slave = the queue itself.
interface wb_write_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        wb_hold;
   logic        RegWrite;
   logic [4:0]  write_addr;
   logic [31:0] write_data;

   modport master (
      output in_valid, in_addr, in_data, wb_hold,
      input  in_ready, RegWrite, write_addr, write_data
   );

   modport slave (
      input  in_valid, in_addr, in_data, wb_hold,
      output in_ready, RegWrite, write_addr, write_data
   );
endinterface

// File: rtl/wb_write_queue.sv
// Register-file writeback queue: FIFO of {addr, data} drained one entry per non-held cycle,
// with pending-write probes for two read ports. Define WB_QUEUE_BYPASS_EN to add bypass data outputs.
module wb_write_queue #(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   wb_write_queue_if.slave wb,
   input  logic [4:0]      read_addr_1,
   input  logic [4:0]      read_addr_2,
   output logic            pending_1,
   output logic            pending_2,
`ifdef WB_QUEUE_BYPASS_EN
   output logic [31:0]     bypass_data_1,
   output logic [31:0]     bypass_data_2,
`endif
   output logic [CW-1:0]   count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [DEPTH-1:0] valid_q, valid_d;

   logic [4:0]  addr_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];

   logic push;
   logic pop;
   logic [DEPTH-1:0] match_1;
   logic [DEPTH-1:0] match_2;

   assign wb.in_ready = (count_q != DEPTH_C) && !reset;
   // Address-0 requests complete the handshake but are dropped here.
   assign push = wb.in_valid && wb.in_ready && (wb.in_addr != 5'd0);
   assign pop  = (count_q != '0) && !wb.wb_hold && !reset;

   assign wb.RegWrite   = pop;
   assign wb.write_addr = pop ? addr_mem[head_q] : 5'd0;
   assign wb.write_data = pop ? data_mem[head_q] : 32'd0;
   assign count         = reset ? '0 : count_q;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      if (pop) begin
         head_d          = head_q + 1'b1;
         valid_d[head_q] = 1'b0;
      end
      if (push) begin
         tail_d          = tail_q + 1'b1;
         valid_d[tail_q] = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage is never reset; the per-slot valid bits hide stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_q] <= wb.in_addr;
         data_mem[tail_q] <= wb.in_data;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_1[gi] = valid_q[gi] && (addr_mem[gi] == read_addr_1);
      assign match_2[gi] = valid_q[gi] && (addr_mem[gi] == read_addr_2);
   end

   assign pending_1 = !reset && (read_addr_1 != 5'd0) && (|match_1);
   assign pending_2 = !reset && (read_addr_2 != 5'd0) && (|match_2);

`ifdef WB_QUEUE_BYPASS_EN
   logic [31:0] byp_1;
   logic [31:0] byp_2;

   // Walk slots oldest to youngest so the last hit is the youngest matching entry.
   always_comb begin
      logic [PW-1:0] slot;
      byp_1 = 32'd0;
      byp_2 = 32'd0;
      slot  = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head_q + PW'(i);
         if (match_1[slot]) byp_1 = data_mem[slot];
         if (match_2[slot]) byp_2 = data_mem[slot];
      end
   end

   assign bypass_data_1 = pending_1 ? byp_1 : 32'd0;
   assign bypass_data_2 = pending_2 ? byp_2 : 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: queue-based reference model compared every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_wb_write_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra1, ra2;
   logic        p1, p2;
   logic [2:0]  cnt;
`ifdef WB_QUEUE_BYPASS_EN
   logic [31:0] bd1, bd2;
`endif

   always #5 clk = ~clk;

   wb_write_queue_if bus();

   wb_write_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb          (bus),
      .read_addr_1 (ra1),
      .read_addr_2 (ra2),
      .pending_1   (p1),
      .pending_2   (p2),
`ifdef WB_QUEUE_BYPASS_EN
      .bypass_data_1 (bd1),
      .bypass_data_2 (bd2),
`endif
      .count       (cnt)
   );

   int checks = 0;
   int errors = 0;
   bit started = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;
   ent_t mq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: plain queue updated by the rules at each rising edge.
   always @(posedge clk) begin
      bit do_pop, do_push;
      if (reset) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() > 0) && !bus.wb_hold;
         do_push = bus.in_valid && (mq.size() < DEPTH) && (bus.in_addr != 5'd0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{a: bus.in_addr, d: bus.in_data});
      end
      started = 1;
   end

   always @(negedge clk) begin
      logic        e_rw;
      logic [4:0]  e_wa;
      logic [31:0] e_wd, e_b1, e_b2;
      logic        e_p1, e_p2;
      if (started) begin
         e_rw = !reset && (mq.size() > 0) && !bus.wb_hold;
         e_wa = e_rw ? mq[0].a : 5'd0;
         e_wd = e_rw ? mq[0].d : 32'd0;
         e_p1 = 1'b0; e_p2 = 1'b0; e_b1 = 32'd0; e_b2 = 32'd0;
         if (!reset) begin
            foreach (mq[i]) begin
               if (ra1 != 5'd0 && mq[i].a == ra1) begin e_p1 = 1'b1; e_b1 = mq[i].d; end
               if (ra2 != 5'd0 && mq[i].a == ra2) begin e_p2 = 1'b1; e_b2 = mq[i].d; end
            end
         end
         check("in_ready",   32'(bus.in_ready),   32'(!reset && mq.size() < DEPTH));
         check("RegWrite",   32'(bus.RegWrite),   32'(e_rw));
         check("write_addr", 32'(bus.write_addr), 32'(e_wa));
         check("write_data", bus.write_data,      e_wd);
         check("pending_1",  32'(p1),             32'(e_p1));
         check("pending_2",  32'(p2),             32'(e_p2));
         check("count",      32'(cnt),            reset ? 32'd0 : 32'(mq.size()));
`ifdef WB_QUEUE_BYPASS_EN
         check("bypass_1",   bd1,                 e_b1);
         check("bypass_2",   bd2,                 e_b2);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
   endtask

   initial begin
      reset = 1'b1;
      ra1 = '0; ra2 = '0;
      bus.wb_hold = 1'b0;
      drive(1'b0, 5'd0, 32'd0);
      tick(); tick();
      check("rst_count",    32'(cnt),          32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_regwrite", 32'(bus.RegWrite), 32'd0);

      // Basic path
      reset = 1'b0;
      drive(1'b1, 5'd5, 32'hDEADBEEF);
      #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      #1;
      check("basic_rw",    32'(bus.RegWrite),   32'd1);
      check("basic_addr",  32'(bus.write_addr), 32'd5);
      check("basic_data",  bus.write_data,      32'hDEADBEEF);
      tick();
      check("basic_count", 32'(cnt),            32'd0);

      // Full and order
      bus.wb_hold = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 5'(k), 32'(k * 32'h100));
         tick();
      end
      drive(1'b1, 5'd9, 32'h999);
      #1;
      check("full_count", 32'(cnt),          32'd4);
      check("full_ready", 32'(bus.in_ready), 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      check("full_ignore", 32'(cnt), 32'd4);
      bus.wb_hold = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("order_rw",   32'(bus.RegWrite),   32'd1);
         check("order_addr", 32'(bus.write_addr), 32'(k));
         check("order_data", bus.write_data,      32'(k * 32'h100));
         tick();
      end
      #1 check("drain_count", 32'(cnt), 32'd0);

      // Zero register
      drive(1'b1, 5'd0, 32'h1234);
      #1 check("zero_ready", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      #1;
      check("zero_count", 32'(cnt),          32'd0);
      check("zero_rw",    32'(bus.RegWrite), 32'd0);
      check("zero_pend",  32'(p1),           32'd0);

      // Pending and bypass
      bus.wb_hold = 1'b1;
      drive(1'b1, 5'd7, 32'h11); tick();
      drive(1'b1, 5'd7, 32'h22); tick();
      drive(1'b0, 5'd0, 32'd0);
      ra2 = 5'd7;
      #1;
      check("pend2_hit",  32'(p2),  32'd1);
      check("pend_count", 32'(cnt), 32'd2);
`ifdef WB_QUEUE_BYPASS_EN
      check("bypass2_young", bd2, 32'h22);
`endif

      // Simultaneous push/pop, then reset mid-drain
      bus.wb_hold = 1'b0;
      drive(1'b1, 5'd3, 32'h33);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      #1 check("simul_count", 32'(cnt), 32'd2);
      tick();
      ra1 = 5'd3;
      #1 check("mid_pend1", 32'(p1), 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid_count", 32'(cnt),          32'd0);
      check("rstmid_rw",    32'(bus.RegWrite), 32'd0);
      check("rstmid_pend1", 32'(p1),           32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("post_ready", 32'(bus.in_ready), 32'd1);
      check("post_count", 32'(cnt),          32'd0);
      check("post_pend1", 32'(p1),           32'd0);
      check("post_pend2", 32'(p2),           32'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset       = ($urandom_range(0, 199) == 0);
         bus.wb_hold = ($urandom_range(0, 99) < ((c < 1500) ? 60 : 25));
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         ra1 = 5'($urandom_range(0, 7));
         ra2 = 5'($urandom_range(0, 7));
      end
      tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  a writeback request is present.
REQ-005 SHALL have port in_ready  output  1  the queue accepts a request this cycle.
REQ-006 SHALL have port in_addr  input  5  destination register of the request.
REQ-007 SHALL have port in_data  input  32  write data of the request.
REQ-008 SHALL have port wb_hold  input  1  the register-file write port is unavailable this cycle.
REQ-009 SHALL have port RegWrite  output  1  write strobe to the register file.
REQ-010 SHALL have port write_addr  output  5  register-file write address.
REQ-011 SHALL have port write_data  output  32  register-file write data.
REQ-012 SHALL have ports read_addr_1 and read_addr_2  input  5 each  register-file read addresses being probed.
REQ-013 SHALL have ports pending_1 and pending_2  output  1 each  a queued write targets the matching read address.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL be a FIFO of {addr, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-016 A push SHALL occur when in_valid && in_ready && in_addr != 0, and SHALL store the request at the tail.
REQ-017 A handshake with in_addr == 0 SHALL complete but SHALL NOT enqueue anything.
REQ-018 in_ready SHALL be (count < DEPTH) && !reset, with no combinational dependence on wb_hold or in_valid.
REQ-019 When count > 0 and !wb_hold, the block SHALL assert RegWrite and drive write_addr/write_data combinationally from the head entry, then pop the head at the clock edge.
REQ-020 When count == 0 or wb_hold == 1, RegWrite SHALL be 0, write_addr SHALL be 0 and write_data SHALL be 0.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and SHALL advance both pointers.
REQ-022 A request accepted at edge N SHALL be presented on the write port no earlier than cycle N+1, with a minimum latency of one cycle.
REQ-023 Entries SHALL drain in strict acceptance order, one per non-held cycle.
REQ-024 pending_k SHALL be 1 iff read_addr_k != 0 and any valid entry, including the head being written this cycle, has addr == read_addr_k.
REQ-025 The in-flight request on in_addr SHALL NOT contribute to pending_k.
REQ-026 When full, in_valid SHALL be ignored and entries SHALL be neither lost nor overwritten; when empty, no pop SHALL occur.

Reset
REQ-027 While reset is high at a rising edge, the block SHALL clear count, head and tail to 0 and SHALL discard all queued entries, including mid-drain.
REQ-028 During and after reset, the block SHALL drive RegWrite=0, write_addr=0, write_data=0, pending_1=pending_2=0 and count=0.
REQ-029 in_ready SHALL be 0 while reset is high, and SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Entry storage SHALL NOT require reset, and its contents SHALL be unobservable while invalid.

Configuration
REQ-031 Macro WB_QUEUE_BYPASS_EN, when defined, SHALL add outputs bypass_data_1 and bypass_data_2 (32 bits each).
REQ-032 Each bypass_data_k SHALL carry the data of the youngest valid entry whose addr matches read_addr_k, and SHALL be 0 when pending_k == 0.
REQ-033 Without WB_QUEUE_BYPASS_EN, the bypass ports and their match-priority logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Basic path: reset, then push {addr 5, data 0xDEADBEEF} with wb_hold=0 -> next cycle RegWrite=1, write_addr=5, write_data=0xDEADBEEF; count returns to 0 the cycle after.
REQ-035 Full and order: hold wb_hold=1 and push addrs 1,2,3,4 (DEPTH 4) -> count=4, in_ready=0, and a fifth push is ignored; release wb_hold -> writes to 1,2,3,4 in order over 4 cycles.
REQ-036 Zero register: push addr 0 -> handshake completes, count stays 0, no RegWrite; read_addr_1=0 -> pending_1=0.
REQ-037 Pending and bypass: with wb_hold=1, push {7,0x11} then {7,0x22}; read_addr_2=7 -> pending_2=1, and bypass_data_2=0x22 when the macro is defined.
REQ-038 Simultaneous and reset: with count=2, push and pop in the same cycle -> count stays 2; assert reset mid-drain -> next cycle count=0, RegWrite=0, pending_1/2=0, and in_ready=1 after release.
